// File: rtl/subtrator_pkg.sv
// subtrator_pkg: shared FSM state type and default width for subtrator_serial
package subtrator_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int SUBT_WIDTH_DEF = 8;
endpackage

// File: rtl/subtrator_completo.sv
// subtrator_completo: combinational 1-bit full subtractor; ports x - y - bin -> d (difference), bout (borrow out)
module subtrator_completo (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  always_comb begin
    d = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
  end
endmodule

// File: rtl/subtrator_serial.sv
// subtrator_serial: bit-serial a - b, LSB first; ports clk, rst, start, a, b -> busy, done, diff, borrow; `SUBTRATOR_SAT_EN clamps diff to 0 on borrow
module subtrator_serial
  import subtrator_pkg::*;
#(
  parameter int WIDTH = SUBT_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] sa, sb, part, res;
  logic br, d, bout, last;
  assign last = cnt == CW'(WIDTH - 1);
  assign res = {d, part[WIDTH-1:1]};
  subtrator_completo u_fs (.x(sa[0]), .y(sb[0]), .bin(br), .d(d), .bout(bout));
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb state_n = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
  always_comb begin
    busy = state == RUN;
    done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sa <= '0;
      sb <= '0;
      part <= '0;
      br <= 1'b0;
      cnt <= '0;
      diff <= '0;
      borrow <= 1'b0;
    end else if (state == IDLE && start) begin
      sa <= a;
      sb <= b;
      br <= 1'b0;
      cnt <= '0;
    end else if (state == RUN) begin
      sa <= sa >> 1;
      sb <= sb >> 1;
      br <= bout;
      part <= res;
      cnt <= last ? '0 : cnt + CW'(1);
      if (last) begin
`ifdef SUBTRATOR_SAT_EN
        diff <= bout ? '0 : res;
`else
        diff <= res;
`endif
        borrow <= bout;
      end
    end
  end
endmodule

// File: tb/tb_subtrator_serial.sv
// tb_subtrator_serial: directed scoreboard bench for subtrator_serial (WIDTH=8)
module tb_subtrator_serial;
  localparam int W = 8;
`ifdef SUBTRATOR_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  typedef struct {
    logic [W-1:0] d;
    logic b;
    int acc;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, busy, done, borrow;
  logic [W-1:0] av = '0, bv = '0, diff;
  logic [W-1:0] prev_d = '0;
  logic prev_b = 1'b0;
  int cyc = 0, checks = 0, errors = 0;
  exp_t q[$];
  subtrator_serial #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(av), .b(bv),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = q.pop_front();
          chk("diff", int'(diff), int'(e.d));
          chk("borrow", int'(borrow), int'(e.b));
          chk("latency", cyc - e.acc, W);
        end
      end
    end
  end
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    av = a;
    bv = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [W-1:0] ed, input logic eb, input bit inject);
    accept(a, b);
    q.push_back('{ed, eb, cyc});
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk("busy_run", int'(busy), 1);
      chk("diff_hold", int'(diff), int'(prev_d));
      if (inject && i == 2) begin
        av = 8'd1;
        bv = 8'd2;
        start = 1'b1;
      end
      if (inject && i == 3) start = 1'b0;
    end
    @(negedge clk);
    chk("busy_done", int'(busy), 0);
    if (inject) begin
      av = 8'd1;
      bv = 8'd2;
      start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse", int'(done), 0);
    chk("busy_idle", int'(busy), 0);
    prev_d = ed;
    prev_b = eb;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_diff", int'(diff), 0);
    chk("rst_borrow", int'(borrow), 0);
    rst = 1'b0;
    op(8'd200, 8'd55, 8'd145, 1'b0, 1'b0);
    op(8'd5, 8'd9, SAT ? 8'h00 : 8'hFC, 1'b1, 1'b0);
    op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
    op(8'h00, 8'h01, SAT ? 8'h00 : 8'hFF, 1'b1, 1'b0);
    op(8'd10, 8'd3, 8'd7, 1'b0, 1'b1);
    op(8'd20, 8'd30, SAT ? 8'h00 : 8'd246, 1'b1, 1'b0);
    accept(8'd50, 8'd20);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_diff", int'(diff), 0);
    chk("mid_rst_borrow", int'(borrow), 0);
    prev_d = '0;
    prev_b = 1'b0;
    repeat (W + 2) @(negedge clk);
    op(8'd100, 8'd1, 8'd99, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
